snake_engine: RTL
=================

SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter GRID_X, default 160, playfield width in cells; legal x is 0..GRID_X-1.
REQ-002 Parameter GRID_Y, default 120, playfield height in cells; legal y is 0..GRID_Y-1.
REQ-003 Parameter MAX_LEN, default 64, power of two, body buffer depth; LEN_W = clog2(MAX_LEN)+1.
REQ-004 Parameter INIT_LEN, default 3, 1..MAX_LEN, starting length; START_X default 80, START_Y default 60, head start cell.
REQ-005 Port clk  in  1  sole clock; all logic is rising-edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port dir_btn  in  4  asynchronous active-low buttons: [3] up, [2] down, [1] left, [0] right.
REQ-008 Port tick  in  1  single-cycle move strobe.
REQ-009 Port grow  in  1  single-cycle food-eaten strobe.
REQ-010 Port draw_ready  in  1  pixel writer accepts the current draw command.
REQ-011 Port draw_valid  out  1  draw command pending.
REQ-012 Port draw_x  out  8  cell x of the command; draw_y  out  7  cell y of the command.
REQ-013 Port draw_erase  out  1  1 = erase cell (tail), 0 = paint cell (head).
REQ-014 Port length  out  LEN_W  current body length.
REQ-015 Port status  out  2  00 INIT, 01 RUN, 10 DEAD, 11 never driven.

Function
REQ-016 Each dir_btn bit SHALL pass through a two-flop synchroniser; a press is a clocked 1->0 edge detect, with no asynchronous edge logic.
REQ-017 Direction encoding SHALL be 2 bits: 00 up, 01 down, 10 left, 11 right; same-cycle presses resolve by priority up > down > left > right.
REQ-018 A press reversing the direction of the last executed move SHALL be discarded; an accepted press overwrites pending_dir, which is applied at the next move.
REQ-019 FSM states SHALL be INIT, RUN, CHECK, ERASE, DRAW and DEAD.
REQ-020 INIT: write INIT_LEN segments one per cycle (head at START_X,START_Y, body extending left), emit a paint command per segment, then enter RUN.
REQ-021 RUN: a tick computes the new head from pending_dir; if it is outside the grid, go to DEAD; otherwise go to CHECK.
REQ-022 CHECK: compare the new head against each stored segment, one per cycle (latency = length cycles); any match goes to DEAD.
REQ-023 The tail segment SHALL be excluded from CHECK unless a growth is pending.
REQ-024 grow SHALL set a sticky grow_pend flag, cleared when consumed; at length = MAX_LEN growth is ignored and the flag is cleared.
REQ-025 After CHECK: if grow_pend, increment length and skip ERASE; otherwise emit an erase of the tail and advance the tail pointer (ERASE).
REQ-026 DRAW: write the new head at head pointer + 1 (mod MAX_LEN), emit a paint command, then return to RUN.
REQ-027 Head and tail pointers SHALL wrap modulo MAX_LEN.
REQ-028 The body SHALL occupy the contiguous circular span from tail to head.
REQ-029 Draw handshake: draw_x, draw_y and draw_erase SHALL be stable while draw_valid=1; a command retires on the edge where draw_valid & draw_ready; the FSM stalls until retirement.
REQ-030 A tick arriving in any state other than RUN SHALL be dropped.
REQ-031 A grow arriving in any state except DEAD SHALL be latched.
REQ-032 DEAD is terminal until reset: no draw commands are issued and all inputs are ignored.
REQ-033 status SHALL reflect the state: INIT -> 00; RUN, CHECK, ERASE, DRAW -> 01; DEAD -> 10.

Reset
REQ-034 While reset=1 at a clock edge, the following SHALL hold: draw_valid=0, draw_x=0, draw_y=0, draw_erase=0, length=0, status=00, pending_dir=right, both pointers 0, grow_pend=0, synchronisers cleared to 1, state INIT.
REQ-035 Reset asserted mid-operation SHALL abandon any pending draw command without a handshake.
REQ-036 Body memory contents need not be cleared by reset.

Structure
REQ-037 Package snake_pkg SHALL hold the direction encoding, status encoding, FSM state type and the default GRID_X/GRID_Y constants.
REQ-038 Sub-module snake_dir_sync SHALL contain the synchroniser, edge detect, priority and reversal filter; body memory SHALL be a register array inside snake_engine.

Verification
REQ-039 Reset, draw_ready=1 -> three paint commands (80,60), (79,60), (78,60); status=01; length=3.
REQ-040 RUN, tick with pending_dir=right and draw_ready=1 -> erase (78,60), then paint (81,60); length stays 3.
REQ-041 Heading right, press left, then tick -> press discarded; new head (81,60).
REQ-042 grow, then tick -> no erase; paint (81,60); length=4; a second tick erases the tail again.
REQ-043 Head at x=159 heading right, then tick -> status=10, no draw command; further ticks and button presses produce nothing.
REQ-044 Hold draw_ready=0 for 5 cycles during a paint -> draw_valid, draw_x and draw_y remain constant; the command retires on the first cycle with draw_ready=1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake engine: directions, status codes, FSM states
// and the default playfield size.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam logic [1:0] ST_INIT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_CHECK = 3'd2,
    S_ERASE = 3'd3,
    S_DRAW  = 3'd4,
    S_DEAD  = 3'd5
  } state_t;

  localparam int DEF_GRID_X = 160;
  localparam int DEF_GRID_Y = 120;

  // Up/down and left/right differ only in bit 0 of the encoding.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

  function automatic logic [1:0] status_of(input state_t s);
    case (s)
      S_INIT:  return ST_INIT;
      S_DEAD:  return ST_DEAD;
      default: return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/snake_dir_sync.sv
// Button synchroniser, press edge detect, priority resolution and reversal filter
// producing the direction to apply at the next move.
module snake_dir_sync
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] dir_btn,
  input  logic       apply,
  output dir_t       pending_dir
);

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] prev_r;
  dir_t       last_r;
  logic [3:0] press_s;
  dir_t       press_dir_s;
  dir_t       ref_dir_s;

  // Active-low buttons: a press is a synchronised 1->0 transition.
  always_comb begin
    press_s = prev_r & ~sync2_r;
    if (press_s[3]) begin
      press_dir_s = DIR_UP;
    end else if (press_s[2]) begin
      press_dir_s = DIR_DOWN;
    end else if (press_s[1]) begin
      press_dir_s = DIR_LEFT;
    end else begin
      press_dir_s = DIR_RIGHT;
    end
    // A move executing this cycle becomes the reference for reversal.
    if (apply) begin
      ref_dir_s = pending_dir;
    end else begin
      ref_dir_s = last_r;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= 4'hF;
      sync2_r     <= 4'hF;
      prev_r      <= 4'hF;
      last_r      <= DIR_RIGHT;
      pending_dir <= DIR_RIGHT;
    end else begin
      sync1_r <= dir_btn;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (apply) last_r <= pending_dir;
      if ((|press_s) && (press_dir_s != opposite(ref_dir_s))) pending_dir <= press_dir_s;
    end
  end

endmodule

// File: rtl/snake_engine.sv
// Snake game engine: circular body buffer, move/collision FSM and a
// valid/ready draw-command stream of head paints and tail erases.
module snake_engine
  import snake_pkg::*;
#(
  parameter int GRID_X   = DEF_GRID_X,
  parameter int GRID_Y   = DEF_GRID_Y,
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 80,
  parameter int START_Y  = 60,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       dir_btn,
  input  logic             tick,
  input  logic             grow,
  input  logic             draw_ready,
  output logic             draw_valid,
  output logic [7:0]       draw_x,
  output logic [6:0]       draw_y,
  output logic             draw_erase,
  output logic [LEN_W-1:0] length,
  output logic [1:0]       status
);

  localparam int PTR_W = $clog2(MAX_LEN);
  localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_INIT_HEAD = PTR_W'(INIT_LEN - 1);
  localparam logic [LEN_W-1:0] LEN_ONE       = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_INIT      = LEN_W'(INIT_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX       = LEN_W'(MAX_LEN);
  localparam logic [7:0]       X_LAST        = 8'(GRID_X - 1);
  localparam logic [6:0]       Y_LAST        = 7'(GRID_Y - 1);

  logic [7:0] body_x [MAX_LEN];
  logic [6:0] body_y [MAX_LEN];

  state_t           state_r, state_s;
  logic [PTR_W-1:0] head_ptr_r, head_ptr_s, tail_ptr_r, tail_ptr_s;
  logic [PTR_W-1:0] chk_idx_r, chk_idx_s;
  logic [LEN_W-1:0] chk_cnt_r, chk_cnt_s, init_cnt_r, init_cnt_s, length_s;
  logic             grow_pend_r, grow_pend_s, grow_take_r, grow_take_s;
  logic [7:0]       new_x_r, new_x_s, nxt_x_s, head_x_s, draw_x_s, wr_x_s;
  logic [6:0]       new_y_r, new_y_s, nxt_y_s, head_y_s, draw_y_s, wr_y_s;
  logic             draw_valid_s, draw_erase_s, draw_free_s, off_grid_s;
  logic             wr_en_s, apply_s;
  logic [PTR_W-1:0] wr_ptr_s;
  dir_t             pending_dir;

  snake_dir_sync u_dir_sync (
    .clk         (clk),
    .reset       (reset),
    .dir_btn     (dir_btn),
    .apply       (apply_s),
    .pending_dir (pending_dir)
  );

  // Candidate head position and wall test for the pending direction.
  always_comb begin
    head_x_s   = body_x[head_ptr_r];
    head_y_s   = body_y[head_ptr_r];
    nxt_x_s    = head_x_s;
    nxt_y_s    = head_y_s;
    off_grid_s = 1'b0;
    case (pending_dir)
      DIR_UP: begin
        off_grid_s = (head_y_s == 7'd0);
        nxt_y_s    = head_y_s - 7'd1;
      end
      DIR_DOWN: begin
        off_grid_s = (head_y_s == Y_LAST);
        nxt_y_s    = head_y_s + 7'd1;
      end
      DIR_LEFT: begin
        off_grid_s = (head_x_s == 8'd0);
        nxt_x_s    = head_x_s - 8'd1;
      end
      default: begin
        off_grid_s = (head_x_s == X_LAST);
        nxt_x_s    = head_x_s + 8'd1;
      end
    endcase
  end

  // Next-state and draw-command logic; commands are issued on state entry
  // and every state that owns a command holds until it retires.
  always_comb begin
    state_s      = state_r;
    head_ptr_s   = head_ptr_r;
    tail_ptr_s   = tail_ptr_r;
    chk_idx_s    = chk_idx_r;
    chk_cnt_s    = chk_cnt_r;
    init_cnt_s   = init_cnt_r;
    length_s     = length;
    grow_take_s  = grow_take_r;
    new_x_s      = new_x_r;
    new_y_s      = new_y_r;
    grow_pend_s  = grow_pend_r | (grow & (state_r != S_DEAD));
    draw_free_s  = ~draw_valid | draw_ready;
    draw_valid_s = draw_valid & ~draw_ready;
    draw_x_s     = draw_x;
    draw_y_s     = draw_y;
    draw_erase_s = draw_erase;
    wr_en_s      = 1'b0;
    wr_ptr_s     = head_ptr_r + PTR_ONE;
    wr_x_s       = new_x_r;
    wr_y_s       = new_y_r;
    apply_s      = 1'b0;
    case (state_r)
      S_INIT: begin
        if (draw_free_s && (init_cnt_r != LEN_INIT)) begin
          wr_en_s      = 1'b1;
          wr_ptr_s     = PTR_INIT_HEAD - init_cnt_r[PTR_W-1:0];
          wr_x_s       = 8'(START_X) - 8'(init_cnt_r);
          wr_y_s       = 7'(START_Y);
          draw_valid_s = 1'b1;
          draw_x_s     = wr_x_s;
          draw_y_s     = wr_y_s;
          draw_erase_s = 1'b0;
          init_cnt_s   = init_cnt_r + LEN_ONE;
          length_s     = length + LEN_ONE;
          head_ptr_s   = PTR_INIT_HEAD;
        end else if (draw_free_s) begin
          state_s = S_RUN;
        end else begin
          state_s = S_INIT;
        end
      end
      S_RUN: begin
        if (tick && off_grid_s) begin
          state_s = S_DEAD;
        end else if (tick) begin
          new_x_s     = nxt_x_s;
          new_y_s     = nxt_y_s;
          apply_s     = 1'b1;
          grow_take_s = grow_pend_r & (length < LEN_MAX);
          grow_pend_s = grow;
          // The tail stays in the collision set only if it will not move.
          if (grow_take_s) begin
            chk_idx_s = tail_ptr_r;
            chk_cnt_s = length;
          end else begin
            chk_idx_s = tail_ptr_r + PTR_ONE;
            chk_cnt_s = length - LEN_ONE;
          end
          state_s = S_CHECK;
        end else begin
          state_s = S_RUN;
        end
      end
      S_CHECK: begin
        if (chk_cnt_r != {LEN_W{1'b0}}) begin
          if ((body_x[chk_idx_r] == new_x_r) && (body_y[chk_idx_r] == new_y_r)) begin
            state_s = S_DEAD;
          end else begin
            chk_idx_s = chk_idx_r + PTR_ONE;
            chk_cnt_s = chk_cnt_r - LEN_ONE;
          end
        end else if (grow_take_r) begin
          length_s     = length + LEN_ONE;
          head_ptr_s   = head_ptr_r + PTR_ONE;
          wr_en_s      = 1'b1;
          draw_valid_s = 1'b1;
          draw_x_s     = new_x_r;
          draw_y_s     = new_y_r;
          draw_erase_s = 1'b0;
          state_s      = S_DRAW;
        end else begin
          draw_valid_s = 1'b1;
          draw_x_s     = body_x[tail_ptr_r];
          draw_y_s     = body_y[tail_ptr_r];
          draw_erase_s = 1'b1;
          state_s      = S_ERASE;
        end
      end
      S_ERASE: begin
        if (draw_ready) begin
          tail_ptr_s   = tail_ptr_r + PTR_ONE;
          head_ptr_s   = head_ptr_r + PTR_ONE;
          wr_en_s      = 1'b1;
          draw_valid_s = 1'b1;
          draw_x_s     = new_x_r;
          draw_y_s     = new_y_r;
          draw_erase_s = 1'b0;
          state_s      = S_DRAW;
        end else begin
          state_s = S_ERASE;
        end
      end
      S_DRAW: begin
        if (draw_ready) begin
          state_s = S_RUN;
        end else begin
          state_s = S_DRAW;
        end
      end
      S_DEAD: begin
        grow_pend_s  = grow_pend_r;
        draw_valid_s = 1'b0;
      end
      default: begin
        state_s = S_INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_INIT;
      head_ptr_r  <= {PTR_W{1'b0}};
      tail_ptr_r  <= {PTR_W{1'b0}};
      chk_idx_r   <= {PTR_W{1'b0}};
      chk_cnt_r   <= {LEN_W{1'b0}};
      init_cnt_r  <= {LEN_W{1'b0}};
      grow_pend_r <= 1'b0;
      grow_take_r <= 1'b0;
      new_x_r     <= 8'd0;
      new_y_r     <= 7'd0;
      draw_valid  <= 1'b0;
      draw_x      <= 8'd0;
      draw_y      <= 7'd0;
      draw_erase  <= 1'b0;
      length      <= {LEN_W{1'b0}};
      status      <= ST_INIT;
    end else begin
      state_r     <= state_s;
      head_ptr_r  <= head_ptr_s;
      tail_ptr_r  <= tail_ptr_s;
      chk_idx_r   <= chk_idx_s;
      chk_cnt_r   <= chk_cnt_s;
      init_cnt_r  <= init_cnt_s;
      grow_pend_r <= grow_pend_s;
      grow_take_r <= grow_take_s;
      new_x_r     <= new_x_s;
      new_y_r     <= new_y_s;
      draw_valid  <= draw_valid_s;
      draw_x      <= draw_x_s;
      draw_y      <= draw_y_s;
      draw_erase  <= draw_erase_s;
      length      <= length_s;
      status      <= status_of(state_s);
    end
  end

  // Body storage carries no reset; only slots between tail and head are ever read.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      body_x[wr_ptr_s] <= wr_x_s;
      body_y[wr_ptr_s] <= wr_y_s;
    end
  end

endmodule
